// File: rtl/adc_window_capture_ctrl.sv
// adc_window_capture_ctrl: triggered [n,m] sample window capture into a framed FWFT FIFO feeding an AXI-stream master
module adc_window_capture_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic [CNT_WIDTH-1:0]  n,
    input  logic [CNT_WIDTH-1:0]  m,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  cont,
    input  logic                  trigger,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  armed,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [CNT_WIDTH-1:0]  trig_miss_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [AW:0] FIT_MAX = (AW+1)'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, ARMED, WINDOW} state_t;

    state_t state, state_nx;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [CNT_WIDTH-1:0] idx, n_l, m_l, seq;
    logic ovf, abort_pending;
    logic push, pop, fits, miss, cfg_bad, ovf_set, frame_end, hdr;
    logic [EW-1:0] push_word;

    assign count = wr_ptr - rd_ptr;
    assign fits = count <= FIT_MAX;
    assign m_axis_tvalid = count != '0;
    assign pop = m_axis_tvalid && m_axis_tready;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];
    assign armed = state == ARMED;
    assign busy = state == WINDOW;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and per-cycle FIFO/event decisions; the last sample always uses the slot reserved by the fits check
    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_word = '0;
        miss      = 1'b0;
        cfg_bad   = 1'b0;
        ovf_set   = 1'b0;
        frame_end = 1'b0;
        hdr       = 1'b0;
        case (state)
            IDLE: state_nx = arm ? ARMED : IDLE;
            ARMED: begin
                if (abort) state_nx = IDLE;
                else if (trigger) begin
                    if (m < n) cfg_bad = 1'b1;
                    else if (fits) begin
                        hdr       = 1'b1;
                        push      = 1'b1;
                        push_word = {2'b00, DATA_WIDTH'(seq)};
                        state_nx  = WINDOW;
                    end else miss = 1'b1;
                end
            end
            WINDOW: begin
                miss = trigger;
                if (adc_valid && idx >= n_l) begin
                    if (idx == m_l) begin
                        push      = 1'b1;
                        push_word = {ovf, 1'b1, adc_data};
                        frame_end = 1'b1;
                        state_nx  = (cont && !abort_pending && !abort) ? ARMED : IDLE;
                    end else if (fits) begin
                        push      = 1'b1;
                        push_word = {2'b00, adc_data};
                    end else ovf_set = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    // pointers, window tracking, sequence and event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            idx             <= '0;
            n_l             <= '0;
            m_l             <= '0;
            seq             <= '0;
            ovf             <= 1'b0;
            abort_pending   <= 1'b0;
            cfg_err         <= 1'b0;
            trig_miss_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            cfg_err <= cfg_bad;
            if (miss && !(&trig_miss_count)) trig_miss_count <= trig_miss_count + CNT_WIDTH'(1);
            if (hdr) begin
                n_l <= n;
                m_l <= m;
                seq <= seq + CNT_WIDTH'(1);
                idx <= '0;
            end else if (busy && adc_valid) idx <= idx + CNT_WIDTH'(1);
            ovf <= (hdr || frame_end) ? 1'b0 : (ovf || ovf_set);
            abort_pending <= (state_nx == WINDOW) && (abort_pending || (busy && abort));
        end
    end
endmodule

// File: tb/tb_adc_window_capture_ctrl.sv
// tb_adc_window_capture_ctrl: directed scoreboard bench for adc_window_capture_ctrl (FIFO_DEPTH=8)
module tb_adc_window_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst, adc_valid, arm, abort, cont, trigger, m_axis_tready;
    logic [15:0] adc_data, n, m;
    logic [15:0] m_axis_tdata, trig_miss_count;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, armed, busy, cfg_err;

    int compared = 0;
    int mismatched = 0;
    logic [17:0] q [$];
    logic        stalled = 1'b0;
    logic [17:0] held;

    adc_window_capture_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .n(n), .m(m), .arm(arm), .abort(abort), .cont(cont), .trigger(trigger),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .armed(armed), .busy(busy), .cfg_err(cfg_err), .trig_miss_count(trig_miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [15:0] d);
        adc_valid = 1'b1;
        adc_data = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        chk(tag, q.size(), 0);
    endtask

    // scoreboard: compare each transferred word and check hold stability under backpressure
    always @(negedge clk) begin
        if (rst) stalled = 1'b0;
        else begin
            if (stalled && m_axis_tvalid) chk("hold", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, held);
            stalled = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) chk("unexpected_word", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 32'hFFFF_FFFF);
                else chk("word", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; adc_valid = 1'b0; adc_data = '0; n = '0; m = '0;
        arm = 1'b0; abort = 1'b0; cont = 1'b0; trigger = 1'b0; m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_miss", trig_miss_count, 0);
        rst = 1'b0;
        tick();

        // basic window n=2..5
        n = 2; m = 5;
        do_arm();
        chk("t1_armed", armed, 1);
        q.push_back(18'h00000);
        do_trigger();
        chk("t1_busy", busy, 1);
        q.push_back({2'b00, 16'h0012});
        q.push_back({2'b00, 16'h0013});
        q.push_back({2'b00, 16'h0014});
        q.push_back({2'b01, 16'h0015});
        for (int i = 0; i < 6; i++) sample(16'h0010 + 16'(i));
        chk("t1_idle_armed", armed, 0);
        chk("t1_idle_busy", busy, 0);
        wait_drain("t1_drain");

        // m < n rejected
        n = 5; m = 3;
        do_arm();
        do_trigger();
        chk("t2_cfg_err_hi", cfg_err, 1);
        chk("t2_armed", armed, 1);
        tick();
        chk("t2_cfg_err_lo", cfg_err, 0);
        chk("t2_no_words", m_axis_tvalid, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t2_abort_idle", armed, 0);

        // overflow under backpressure, depth 8
        m_axis_tready = 1'b0;
        n = 0; m = 19;
        do_arm();
        q.push_back(18'h00001);
        do_trigger();
        for (int i = 0; i < 6; i++) q.push_back({2'b00, 16'h0100 + 16'(i)});
        q.push_back({2'b11, 16'h0113});
        for (int i = 0; i < 20; i++) sample(16'h0100 + 16'(i));
        chk("t3_stalled_valid", m_axis_tvalid, 1);
        chk("t3_stalled_header", m_axis_tdata, 16'h0001);
        repeat (3) tick();
        m_axis_tready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_miss", trig_miss_count, 0);

        // continuous mode, trigger during window
        cont = 1'b1; n = 0; m = 1;
        do_arm();
        q.push_back(18'h00002);
        q.push_back({2'b00, 16'h0020});
        q.push_back({2'b01, 16'h0021});
        do_trigger();
        trigger = 1'b1;
        sample(16'h0020);
        trigger = 1'b0;
        sample(16'h0021);
        chk("t4_miss_window", trig_miss_count, 1);
        chk("t4_rearmed", armed, 1);
        q.push_back(18'h00003);
        q.push_back({2'b00, 16'h0030});
        q.push_back({2'b01, 16'h0031});
        do_trigger();
        sample(16'h0030);
        sample(16'h0031);
        chk("t4_rearmed2", armed, 1);
        wait_drain("t4_drain1");
        m_axis_tready = 1'b0;
        for (int f = 4; f < 6; f++) begin
            q.push_back({2'b00, 16'(f)});
            q.push_back({2'b00, 16'(f << 4)});
            q.push_back({2'b01, 16'(f << 4) + 16'h1});
            do_trigger();
            sample(16'(f << 4));
            sample(16'(f << 4) + 16'h1);
        end
        q.push_back(18'h00006);
        q.push_back({2'b11, 16'h0061});
        do_trigger();
        sample(16'h0060);
        sample(16'h0061);
        do_trigger();
        chk("t4_miss_full", trig_miss_count, 2);
        chk("t4_full_armed", armed, 1);
        m_axis_tready = 1'b1;
        wait_drain("t4_drain2");

        // abort during window completes the frame then idles
        n = 0; m = 7;
        q.push_back(18'h00007);
        for (int i = 0; i < 7; i++) q.push_back({2'b00, 16'h0070 + 16'(i)});
        q.push_back({2'b01, 16'h0077});
        do_trigger();
        for (int i = 0; i < 8; i++) begin
            abort = (i == 3);
            sample(16'h0070 + 16'(i));
        end
        abort = 1'b0;
        chk("t5_idle_armed", armed, 0);
        chk("t5_idle_busy", busy, 0);
        wait_drain("t5_drain");
        n = 0; m = 0;
        do_arm();
        q.push_back(18'h00008);
        q.push_back({2'b01, 16'h0080});
        do_trigger();
        sample(16'h0080);
        chk("t5_pending_cleared", armed, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_armed", armed, 0);
        wait_drain("t5_drain2");

        // reset mid-window discards queued words
        cont = 1'b0; m_axis_tready = 1'b0; n = 0; m = 9;
        do_arm();
        do_trigger();
        sample(16'h00A0);
        sample(16'h00A1);
        chk("t6_queued", m_axis_tvalid, 1);
        rst = 1'b1;
        tick();
        chk("t6_tvalid_cleared", m_axis_tvalid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_miss_cleared", trig_miss_count, 0);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        n = 1; m = 2;
        do_arm();
        q.push_back(18'h00000);
        q.push_back({2'b00, 16'h00B1});
        q.push_back({2'b01, 16'h00B2});
        do_trigger();
        sample(16'h00B0);
        sample(16'h00B1);
        sample(16'h00B2);
        wait_drain("t6_drain");
        chk("t6_miss_final", trig_miss_count, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
